// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
// Module      : mdio_master
// Description : MDIO management-frame master with host read/write path and an
//               optional periodic status poll (define MDIO_MASTER_POLL_EN).
// Revision    : 1.0
// ============================================================================
module mdio_master #(
    parameter logic [4:0] POLL_PHYAD = 5'd1,
    parameter logic [4:0] POLL_REGAD = 5'd1
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        mdcclk,
    input  logic        mdsevt,
    input  logic        cmd_req,
    input  logic        cmd_wr,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        cmd_ack,
    output logic        done,
    output logic        busy,
    output logic [15:0] rdata,
    output logic [15:0] poll_sts,
    output logic        link_up,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4
    } state_t;

    localparam logic [5:0] c_last_bit = 6'd63;
    localparam logic [5:0] c_last_drv = 6'd45;

    state_t      r_state;
    logic        r_mdc_q;
    logic [5:0]  r_cnt;
    logic        r_wr;
    logic [4:0]  r_phyad;
    logic [4:0]  r_regad;
    logic [15:0] r_wdata;
    logic [15:0] r_shift;

    logic        w_rise;
    logic        w_fall;
    logic [5:0]  w_next;
    logic [63:0] w_frame;
    logic        w_next_oe;
    logic        w_next_bit;
    logic        w_is_poll;
    state_t      w_next_state;

    assign w_rise = mdcclk & ~r_mdc_q;
    assign w_fall = ~mdcclk & r_mdc_q;
    assign mdc    = r_mdc_q;

    // Whole frame as one MSB-first vector; bit n of the wire is w_frame[63-n].
    assign w_frame    = {32'hFFFF_FFFF, 2'b01, (r_wr ? 2'b01 : 2'b10),
                         r_phyad, r_regad, 2'b10, r_wdata};
    assign w_next     = r_cnt + 6'd1;
    assign w_next_oe  = r_wr | (w_next <= c_last_drv);
    assign w_next_bit = w_frame[6'd63 - w_next];

    always_comb begin
        w_next_state = S_DATA;
        if (w_next < 6'd32)
            w_next_state = S_PRE;
        else if (w_next < 6'd46)
            w_next_state = S_HDR;
        else if (w_next < 6'd48)
            w_next_state = S_TA;
    end

`ifdef MDIO_MASTER_POLL_EN
    logic r_mdsevt_q;
    logic r_poll_pend;
    logic r_poll;
    logic w_poll_evt;

    assign w_poll_evt = mdsevt & ~r_mdsevt_q;
    assign w_is_poll  = r_poll;
`else
    logic w_unused_poll;

    assign w_unused_poll = ^{mdsevt, POLL_PHYAD, POLL_REGAD};
    assign w_is_poll     = 1'b0;
    assign poll_sts      = 16'h0000;
`endif

    assign link_up = poll_sts[2];

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_mdc_q   <= 1'b0;
            r_wr      <= 1'b0;
            r_phyad   <= 5'd0;
            r_regad   <= 5'd0;
            r_wdata   <= 16'h0000;
            r_shift   <= 16'h0000;
            cmd_ack   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            mdio_o    <= 1'b0;
            mdio_oe   <= 1'b0;
            rdata     <= 16'h0000;
`ifdef MDIO_MASTER_POLL_EN
            r_mdsevt_q  <= 1'b0;
            r_poll_pend <= 1'b0;
            r_poll      <= 1'b0;
            poll_sts    <= 16'h0000;
`endif
        end else begin
            cmd_ack <= 1'b0;
            done    <= 1'b0;
            r_mdc_q <= mdcclk;
`ifdef MDIO_MASTER_POLL_EN
            r_mdsevt_q <= mdsevt;
`endif
            // Turnaround has released the line; the PHY's data is valid at MDC rise.
            if (w_rise && (r_state == S_DATA) && !r_wr)
                r_shift <= {r_shift[14:0], mdio_i};

            if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (cmd_req) begin
                            r_wr    <= cmd_wr;
                            r_phyad <= cmd_phyad;
                            r_regad <= cmd_regad;
                            r_wdata <= cmd_wdata;
                            cmd_ack <= 1'b1;
                            r_state <= S_PRE;
                            r_cnt   <= 6'd0;
                            busy    <= 1'b1;
                            mdio_oe <= 1'b1;
                            mdio_o  <= 1'b1;
`ifdef MDIO_MASTER_POLL_EN
                            r_poll  <= 1'b0;
                        end else if (r_poll_pend) begin
                            r_wr        <= 1'b0;
                            r_phyad     <= POLL_PHYAD;
                            r_regad     <= POLL_REGAD;
                            r_wdata     <= 16'h0000;
                            r_poll      <= 1'b1;
                            r_poll_pend <= 1'b0;
                            r_state     <= S_PRE;
                            r_cnt       <= 6'd0;
                            busy        <= 1'b1;
                            mdio_oe     <= 1'b1;
                            mdio_o      <= 1'b1;
`endif
                        end
                    end
                    default: begin
                        if (r_cnt == c_last_bit) begin
                            r_state <= S_IDLE;
                            r_cnt   <= 6'd0;
                            busy    <= 1'b0;
                            mdio_oe <= 1'b0;
                            mdio_o  <= 1'b0;
                            done    <= ~w_is_poll;
                            if (!r_wr && !w_is_poll)
                                rdata <= r_shift;
`ifdef MDIO_MASTER_POLL_EN
                            if (!r_wr && r_poll)
                                poll_sts <= r_shift;
`endif
                        end else begin
                            r_state <= w_next_state;
                            r_cnt   <= w_next;
                            mdio_oe <= w_next_oe;
                            mdio_o  <= w_next_oe & w_next_bit;
                        end
                    end
                endcase
            end

`ifdef MDIO_MASTER_POLL_EN
            // A fresh event during a poll load re-arms the request rather than being lost.
            if (w_poll_evt)
                r_poll_pend <= 1'b1;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`default_nettype none
// Testbench for mdio_master: PHY model on the MDIO pads, frame capture per MDC
// bit, and a field-level reference model of the expected frame.
module tb_mdio_master;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        mdcclk = 1'b0;
    logic        mdsevt = 1'b0;
    logic        cmd_req = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [4:0]  cmd_phyad = 5'd0;
    logic [4:0]  cmd_regad = 5'd0;
    logic [15:0] cmd_wdata = 16'h0000;
    logic        cmd_ack;
    logic        done;
    logic        busy;
    logic [15:0] rdata;
    logic [15:0] poll_sts;
    logic        link_up;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mdc_div = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int ack_cnt = 0;
    logic [15:0] exp_rdata = 16'h0000;

    localparam int FRAME_CLKS = 64 * 22;

    mdio_master #(
        .POLL_PHYAD(5'd1),
        .POLL_REGAD(5'd1)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .mdcclk   (mdcclk),
        .mdsevt   (mdsevt),
        .cmd_req  (cmd_req),
        .cmd_wr   (cmd_wr),
        .cmd_phyad(cmd_phyad),
        .cmd_regad(cmd_regad),
        .cmd_wdata(cmd_wdata),
        .cmd_ack  (cmd_ack),
        .done     (done),
        .busy     (busy),
        .rdata    (rdata),
        .poll_sts (poll_sts),
        .link_up  (link_up),
        .mdc      (mdc),
        .mdio_o   (mdio_o),
        .mdio_oe  (mdio_oe),
        .mdio_i   (mdio_i)
    );

    always #10 clock = ~clock;

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        mdc_div <= (mdc_div == 21) ? 0 : mdc_div + 1;
        mdcclk  <= (mdc_div < 11);
    end

    always @(negedge clock) begin
        if (done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (cmd_ack === 1'b1)
            ack_cnt <= ack_cnt + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    // Reference model: frame fields straight from the MDIO frame layout.
    function automatic logic [63:0] model_oe(input logic wr);
        return wr ? {64{1'b1}} : {{46{1'b1}}, {18{1'b0}}};
    endfunction

    function automatic logic [63:0] model_bits(input logic wr, input logic [4:0] phy,
                                               input logic [4:0] rg, input logic [15:0] data);
        logic [63:0] f;
        f = {32'hFFFF_FFFF, 2'b01, (wr ? 2'b01 : 2'b10), phy, rg, 2'b10, data};
        return f & model_oe(wr);
    endfunction

    task automatic wait_mdc(input logic lvl, output bit to);
        to = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (mdc === lvl) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_busy(output bit to, output int start);
        to = 1'b1;
        start = 0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if (busy === 1'b1) begin
                to = 1'b0;
                start = cyc;
                break;
            end
        end
    endtask

    // Called at the negedge where bit 0 is on the wire; returns at the negedge after bit 63.
    task automatic capture(input bit drive, input logic [15:0] val, output logic [63:0] ob,
                           output logic [63:0] oeb, output int endc, output bit to);
        bit t;
        logic [15:0] sh;
        sh = val;
        to = 1'b0;
        ob = '0;
        oeb = '0;
        for (int n = 0; n < 64; n++) begin
            if (drive && n >= 48) begin
                mdio_i = sh[15];
                sh = sh << 1;
            end else begin
                mdio_i = 1'b0;
            end
            wait_mdc(1'b1, t);
            to |= t;
            ob  = {ob[62:0], mdio_o};
            oeb = {oeb[62:0], mdio_oe};
            wait_mdc(1'b0, t);
            to |= t;
        end
        mdio_i = 1'b0;
        endc = cyc;
    endtask

    task automatic host_frame(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                              input logic [15:0] wd, input logic [15:0] phyval,
                              output logic [63:0] ob, output logic [63:0] oeb,
                              output int s, output int e, output bit ack, output bit to);
        bit t1;
        cmd_wr = wr;
        cmd_phyad = phy;
        cmd_regad = rg;
        cmd_wdata = wd;
        cmd_req = 1'b1;
        wait_busy(t1, s);
        ack = (cmd_ack === 1'b1);
        cmd_req = 1'b0;
        ob = '0;
        oeb = '0;
        e = s;
        to = t1;
        if (!t1)
            capture(!wr, phyval, ob, oeb, e, to);
    endtask

    task automatic test_reset;
        @(negedge clock);
        checks++;
        if ({busy, mdio_oe, mdio_o, cmd_ack, done} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {busy, mdio_oe, mdio_o, cmd_ack, done});
        checks++;
        if (rdata !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rdata got %h want 0000", rdata);
        end
        checks++;
        if (poll_sts !== 16'h0000 || link_up !== 1'b0) begin
            errors++;
            $display("FAIL reset_poll got %h/%b want 0000/0", poll_sts, link_up);
        end
        rst = 1'b0;
        repeat (50) @(negedge clock);
        checks++;
        if (busy !== 1'b0 || mdio_oe !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b oe=%b want 0/0", busy, mdio_oe);
        end
    endtask

    task automatic test_write;
        logic [63:0] ob, oeb;
        int s, e, d0, a0;
        bit ack, to;
        d0 = done_cnt;
        a0 = ack_cnt;
        host_frame(1'b1, 5'd1, 5'd0, 16'h1200, 16'h0000, ob, oeb, s, e, ack, to);
        @(negedge clock);
        checks++;
        if (to || ob !== 64'hFFFF_FFFF_5082_1200) begin
            errors++;
            $display("FAIL write_stream got %h want ffffffff50821200 timeout=%0d", ob, to);
        end
        checks++;
        if (oeb !== {64{1'b1}}) begin
            errors++;
            $display("FAIL write_oe got %h want all ones", oeb);
        end
        checks++;
        if (!ack || ack_cnt - a0 != 1) begin
            errors++;
            $display("FAIL write_ack got seen=%0d pulses=%0d want 1/1", ack, ack_cnt - a0);
        end
        checks++;
        if (done_cnt - d0 != 1 || done_cyc - s != FRAME_CLKS) begin
            errors++;
            $display("FAIL write_done got pulses=%0d delay=%0d want 1/%0d",
                     done_cnt - d0, done_cyc - s, FRAME_CLKS);
        end
    endtask

    task automatic test_read;
        logic [63:0] ob, oeb;
        int s, e, d0;
        bit ack, to;
        d0 = done_cnt;
        host_frame(1'b0, 5'd3, 5'd2, 16'h0000, 16'h0141, ob, oeb, s, e, ack, to);
        @(negedge clock);
        exp_rdata = 16'h0141;
        checks++;
        if (to || ob !== 64'hFFFF_FFFF_6188_0000) begin
            errors++;
            $display("FAIL read_stream got %h want ffffffff61880000 timeout=%0d", ob, to);
        end
        checks++;
        if (oeb !== 64'hFFFF_FFFF_FFFC_0000) begin
            errors++;
            $display("FAIL read_oe got %h want fffffffffffc0000", oeb);
        end
        checks++;
        if (rdata !== exp_rdata) begin
            errors++;
            $display("FAIL read_rdata got %h want %h", rdata, exp_rdata);
        end
        checks++;
        if (done_cnt - d0 != 1 || e - s != FRAME_CLKS) begin
            errors++;
            $display("FAIL read_done got pulses=%0d len=%0d want 1/%0d", done_cnt - d0, e - s, FRAME_CLKS);
        end
    endtask

    task automatic test_random;
        logic [63:0] ob, oeb;
        logic        wr;
        logic [4:0]  phy, rg;
        logic [15:0] wd, pv;
        int s, e, d0, a0;
        bit ack, to;
        for (int i = 0; i < 8; i++) begin
            wr = 1'($urandom_range(0, 1));
            phy = 5'($urandom);
            rg = 5'($urandom);
            wd = 16'($urandom);
            pv = 16'($urandom);
            d0 = done_cnt;
            a0 = ack_cnt;
            host_frame(wr, phy, rg, wd, pv, ob, oeb, s, e, ack, to);
            @(negedge clock);
            if (!wr)
                exp_rdata = pv;
            checks++;
            if (to || ob !== model_bits(wr, phy, rg, wd)) begin
                errors++;
                $display("FAIL rand_stream[%0d] got %h want %h timeout=%0d", i, ob, model_bits(wr, phy, rg, wd), to);
            end
            checks++;
            if (oeb !== model_oe(wr)) begin
                errors++;
                $display("FAIL rand_oe[%0d] got %h want %h", i, oeb, model_oe(wr));
            end
            checks++;
            if (e - s != FRAME_CLKS || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_len[%0d] got %0d busy=%b want %0d/0", i, e - s, busy, FRAME_CLKS);
            end
            checks++;
            if (!ack || ack_cnt - a0 != 1 || done_cnt - d0 != 1) begin
                errors++;
                $display("FAIL rand_handshake[%0d] got ack=%0d/%0d done=%0d want 1/1/1",
                         i, ack, ack_cnt - a0, done_cnt - d0);
            end
            checks++;
            if (rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rand_rdata[%0d] got %h want %h", i, rdata, exp_rdata);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] ob1, oeb1, ob2, oeb2;
        int s1, e1, s2, e2;
        bit ack1, to1, ack2, to2;
        logic [15:0] wd, pv;
        wd = 16'($urandom);
        pv = 16'($urandom);
        host_frame(1'b1, 5'd7, 5'd9, wd, 16'h0000, ob1, oeb1, s1, e1, ack1, to1);
        host_frame(1'b0, 5'd7, 5'd9, 16'h0000, pv, ob2, oeb2, s2, e2, ack2, to2);
        @(negedge clock);
        exp_rdata = pv;
        checks++;
        if (to1 || to2 || s2 - e1 != 22) begin
            errors++;
            $display("FAIL b2b_gap got %0d clocks want 22 timeout=%0d/%0d", s2 - e1, to1, to2);
        end
        checks++;
        if (ob1 !== model_bits(1'b1, 5'd7, 5'd9, wd) || ob2 !== model_bits(1'b0, 5'd7, 5'd9, 16'h0000)) begin
            errors++;
            $display("FAIL b2b_stream got %h %h", ob1, ob2);
        end
        checks++;
        if (rdata !== exp_rdata) begin
            errors++;
            $display("FAIL b2b_rdata got %h want %h", rdata, exp_rdata);
        end
    endtask

`ifdef MDIO_MASTER_POLL_EN
    task automatic test_poll;
        logic [63:0] ob, oeb;
        int s, e, d0, a0;
        bit t, to, extra;
        d0 = done_cnt;
        a0 = ack_cnt;
        wait_mdc(1'b1, t);
        wait_mdc(1'b0, t);
        // Two event edges before the next MDC fall must merge into one poll.
        for (int k = 0; k < 2; k++) begin
            mdsevt = 1'b1;
            repeat (2) @(negedge clock);
            mdsevt = 1'b0;
            repeat (2) @(negedge clock);
        end
        wait_busy(to, s);
        ob = '0;
        oeb = '0;
        e = s;
        if (!to)
            capture(1'b1, 16'h786D, ob, oeb, e, to);
        extra = 1'b0;
        repeat (100) begin
            @(negedge clock);
            if (busy !== 1'b0)
                extra = 1'b1;
        end
        checks++;
        if (to || ob !== model_bits(1'b0, 5'd1, 5'd1, 16'h0000) || oeb !== model_oe(1'b0)) begin
            errors++;
            $display("FAIL poll_stream got %h oe %h timeout=%0d", ob, oeb, to);
        end
        checks++;
        if (poll_sts !== 16'h786D || link_up !== 1'b1) begin
            errors++;
            $display("FAIL poll_sts got %h/%b want 786d/1", poll_sts, link_up);
        end
        checks++;
        if (done_cnt != d0 || ack_cnt != a0 || rdata !== exp_rdata) begin
            errors++;
            $display("FAIL poll_side got done=%0d ack=%0d rdata=%h want 0/0/%h",
                     done_cnt - d0, ack_cnt - a0, rdata, exp_rdata);
        end
        checks++;
        if (extra) begin
            errors++;
            $display("FAIL poll_coalesce got second frame want none");
        end
    endtask

    task automatic test_priority;
        logic [63:0] ob1, oeb1, ob2, oeb2;
        int s1, e1, s2, e2, d0;
        bit t, ack, to1, to2;
        logic [15:0] hv, pv;
        hv = 16'($urandom);
        pv = 16'($urandom);
        d0 = done_cnt;
        wait_mdc(1'b1, t);
        wait_mdc(1'b0, t);
        mdsevt = 1'b1;
        host_frame(1'b0, 5'd4, 5'd5, 16'h0000, hv, ob1, oeb1, s1, e1, ack, to1);
        mdsevt = 1'b0;
        wait_busy(to2, s2);
        ob2 = '0;
        oeb2 = '0;
        e2 = s2;
        if (!to2)
            capture(1'b1, pv, ob2, oeb2, e2, to2);
        @(negedge clock);
        exp_rdata = hv;
        checks++;
        if (to1 || !ack || ob1 !== model_bits(1'b0, 5'd4, 5'd5, 16'h0000)) begin
            errors++;
            $display("FAIL prio_host_first got %h ack=%0d timeout=%0d", ob1, ack, to1);
        end
        checks++;
        if (to2 || s2 - e1 != 22 || ob2 !== model_bits(1'b0, 5'd1, 5'd1, 16'h0000)) begin
            errors++;
            $display("FAIL prio_poll_next got gap=%0d stream=%h timeout=%0d want 22", s2 - e1, ob2, to2);
        end
        checks++;
        if (rdata !== exp_rdata || poll_sts !== pv || link_up !== pv[2] || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL prio_results got rdata=%h poll=%h link=%b done=%0d want %h/%h/%b/1",
                     rdata, poll_sts, link_up, done_cnt - d0, exp_rdata, pv, pv[2]);
        end
    endtask
`else
    task automatic test_poll_disabled;
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            mdsevt = ~mdsevt;
            repeat ($urandom_range(5, 40)) begin
                @(negedge clock);
                if (busy !== 1'b0)
                    seen = 1'b1;
            end
        end
        mdsevt = 1'b0;
        repeat (100) begin
            @(negedge clock);
            if (busy !== 1'b0)
                seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL nopoll_busy got busy=1 want 0");
        end
        checks++;
        if (link_up !== 1'b0 || poll_sts !== 16'h0000) begin
            errors++;
            $display("FAIL nopoll_sts got %h/%b want 0000/0", poll_sts, link_up);
        end
    endtask
`endif

    task automatic test_reset_midframe;
        logic [63:0] ob, oeb;
        int s, e, d0;
        bit t, to, ack;
        logic oe_before;
        logic [15:0] wd;
        cmd_wr = 1'b1;
        cmd_phyad = 5'd2;
        cmd_regad = 5'd3;
        cmd_wdata = 16'hA5C3;
        cmd_req = 1'b1;
        wait_busy(to, s);
        cmd_req = 1'b0;
        repeat (40) begin
            wait_mdc(1'b1, t);
            wait_mdc(1'b0, t);
        end
        oe_before = mdio_oe;
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        checks++;
        if (to || oe_before !== 1'b1 || mdio_oe !== 1'b0 || busy !== 1'b0 || mdio_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got oe_before=%b oe=%b busy=%b o=%b want 1/0/0/0",
                     oe_before, mdio_oe, busy, mdio_o);
        end
        repeat (3) @(negedge clock);
        rst = 1'b0;
        exp_rdata = 16'h0000;
        repeat (200) @(negedge clock);
        checks++;
        if (done_cnt != d0 || busy !== 1'b0 || rdata !== exp_rdata) begin
            errors++;
            $display("FAIL midreset_abandon got done=%0d busy=%b rdata=%h want 0/0/0000",
                     done_cnt - d0, busy, rdata);
        end
        wd = 16'($urandom);
        host_frame(1'b1, 5'd2, 5'd3, wd, 16'h0000, ob, oeb, s, e, ack, to);
        @(negedge clock);
        checks++;
        if (to || !ack || ob !== model_bits(1'b1, 5'd2, 5'd3, wd) || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL midreset_recover got %h ack=%0d done=%0d want %h/1/1",
                     ob, ack, done_cnt - d0, model_bits(1'b1, 5'd2, 5'd3, wd));
        end
    endtask

    initial begin
        repeat (5) @(negedge clock);
        test_reset;
        test_write;
        test_read;
        test_random;
        test_back_to_back;
`ifdef MDIO_MASTER_POLL_EN
        test_poll;
        test_priority;
`else
        test_poll_disabled;
`endif
        test_reset_midframe;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
